js_counter_gen: RTL and testbench



---
 rtl/js_pkg.sv | 21 ++
 rtl/js_counter_gen_if.sv | 27 ++
 rtl/js_phase_decode.sv | 55 +++++
 rtl/js_counter_gen.sv | 97 +++++++++
 tb/tb_js_counter_gen.sv | 128 ++++++++++++
 5 files changed

// File: rtl/js_pkg.sv
// Shared constants and helpers for the js_counter_gen shift-register counter
// family (Johnson / ring phase generator).
package js_pkg;

   // Sequencing mode select
   localparam logic JS_MODE_JOHNSON = 1'b0;
   localparam logic JS_MODE_RING    = 1'b1;

   // Step direction select
   localparam logic JS_DIR_UP = 1'b0;
   localparam logic JS_DIR_DN = 1'b1;

   // Reset / recovery value: legal in both modes (index 1 Johnson, 0 ring)
   localparam int JS_SEED = 1;

   // Highest phase index reachable in the given mode for a width-w counter
   function automatic int js_last_index(input logic mode, input int w);
      return (mode == JS_MODE_RING) ? (w - 1) : (2 * w - 1);
   endfunction

endpackage

// File: rtl/js_counter_gen_if.sv
// Control/status bundle between a sequencer client (master) and the
// js_counter_gen phase generator (slave).
interface js_counter_gen_if #(
   parameter int DATA_WID = 8
) ();
   localparam int PH_WID = $clog2(2 * DATA_WID);

   logic                en;
   logic                dir;
   logic                mode;
   logic                load;
   logic [DATA_WID-1:0] load_data;
   logic [DATA_WID-1:0] Data;
   logic [PH_WID-1:0]   phase;
   logic                wrap;
   logic                err;

   modport master (
      output en, dir, mode, load, load_data,
      input  Data, phase, wrap, err
   );

   modport slave (
      input  en, dir, mode, load, load_data,
      output Data, phase, wrap, err
   );
endinterface

// File: rtl/js_phase_decode.sv
// Combinational legality check and phase-index decode of a Johnson or ring
// state word. Illegal words decode to phase 0.
module js_phase_decode
   import js_pkg::*;
#(
   parameter  int DATA_WID = 8,
   localparam int PH_WID   = $clog2(2 * DATA_WID)
) (
   input  logic [DATA_WID-1:0] data,
   input  logic                mode,
   output logic                legal,
   output logic [PH_WID-1:0]   phase
);

   // A Johnson-legal word has at most one boundary between adjacent bits
   logic [DATA_WID-2:0] edge_vec;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WID - 1; gi++) begin : g_edge
         assign edge_vec[gi] = data[gi + 1] ^ data[gi];
      end
   endgenerate

   int                pop_cnt;
   int                edge_cnt;
   logic [PH_WID-1:0] ring_pos;

   // Popcount, boundary count and one-hot position, then mode-specific decode
   always_comb begin
      pop_cnt  = 0;
      edge_cnt = 0;
      ring_pos = '0;
      legal    = 1'b0;
      phase    = '0;
      for (int i = 0; i < DATA_WID; i++) begin
         pop_cnt = pop_cnt + int'(data[i]);
         if (data[i]) ring_pos = PH_WID'(i);
      end
      for (int i = 0; i < DATA_WID - 1; i++) begin
         edge_cnt = edge_cnt + int'(edge_vec[i]);
      end
      if (mode == JS_MODE_RING) begin
         legal = (pop_cnt == 1);
         if (legal) phase = ring_pos;
      end else begin
         legal = (edge_cnt <= 1);
         if (legal) begin
            phase = data[DATA_WID-1] ? PH_WID'(2 * DATA_WID - pop_cnt)
                                     : PH_WID'(pop_cnt);
         end
      end
   end

endmodule

// File: rtl/js_counter_gen.sv
// Parametrised Johnson / ring shift-register counter with up/down stepping,
// parallel load, registered phase index, wrap pulse and illegal-state flag.
// Optional build macro JS_SELF_CORRECT_EN: when defined, an illegal state is
// replaced by the seed on the next edge (unless a load is in progress).
module js_counter_gen
   import js_pkg::*;
#(
   parameter  int DATA_WID = 8,
   localparam int PH_WID   = $clog2(2 * DATA_WID)
) (
   input logic             clk,
   input logic             rst_n,
   js_counter_gen_if.slave bus
);

   localparam logic [DATA_WID-1:0] SEED = DATA_WID'(JS_SEED);

   logic [DATA_WID-1:0] data_reg;
   logic [DATA_WID-1:0] data_next;
   logic [DATA_WID-1:0] data_step;
   logic [PH_WID-1:0]   phase_reg;
   logic [PH_WID-1:0]   phase_next;
   logic                wrap_reg;
   logic                wrap_next;
   logic                err_reg;
   logic                cur_legal;
   logic [PH_WID-1:0]   cur_phase;
   logic                nxt_legal_unused;
   logic [PH_WID-1:0]   last_phase;

   // Decode of the state currently held, against the current mode
   js_phase_decode #(.DATA_WID(DATA_WID)) u_dec_cur (
      .data  (data_reg),
      .mode  (bus.mode),
      .legal (cur_legal),
      .phase (cur_phase)
   );

   // Decode of the state about to be registered, so phase lands with Data
   js_phase_decode #(.DATA_WID(DATA_WID)) u_dec_nxt (
      .data  (data_next),
      .mode  (bus.mode),
      .legal (nxt_legal_unused),
      .phase (phase_next)
   );

   assign last_phase = PH_WID'(js_last_index(bus.mode, DATA_WID));

   // Shift rule for one step in the selected mode and direction
   always_comb begin
      data_step = data_reg;
      case ({bus.mode, bus.dir})
         {JS_MODE_JOHNSON, JS_DIR_UP}: data_step = {data_reg[DATA_WID-2:0], ~data_reg[DATA_WID-1]};
         {JS_MODE_JOHNSON, JS_DIR_DN}: data_step = {~data_reg[0], data_reg[DATA_WID-1:1]};
         {JS_MODE_RING,    JS_DIR_UP}: data_step = {data_reg[DATA_WID-2:0], data_reg[DATA_WID-1]};
         default:                      data_step = {data_reg[0], data_reg[DATA_WID-1:1]};
      endcase
   end

   // Priority mux: load > self-correct (optional) > step > hold; wrap only on a legal step across the end
   always_comb begin
      data_next = data_reg;
      wrap_next = 1'b0;
      if (bus.load) begin
         data_next = bus.load_data;
`ifdef JS_SELF_CORRECT_EN
      end else if (!cur_legal) begin
         data_next = SEED;
`endif
      end else if (bus.en) begin
         data_next = data_step;
         if (bus.dir == JS_DIR_UP) wrap_next = cur_legal && (cur_phase == last_phase);
         else                      wrap_next = cur_legal && (cur_phase == '0);
      end
   end

   // Output registers; reset phase reflects the seed's index in the mode present at reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg  <= SEED;
         phase_reg <= (bus.mode == JS_MODE_RING) ? PH_WID'(0) : PH_WID'(1);
         wrap_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         data_reg  <= data_next;
         phase_reg <= phase_next;
         wrap_reg  <= wrap_next;
         err_reg   <= ~cur_legal;
      end
   end

   assign bus.Data  = data_reg;
   assign bus.phase = phase_reg;
   assign bus.wrap  = wrap_reg;
   assign bus.err   = err_reg;

endmodule

// File: tb/tb_js_counter_gen.sv
// Directed bench for js_counter_gen at DATA_WID = 4. Expectations follow the
// build macro JS_SELF_CORRECT_EN where the self-correct behaviour matters.
module tb_js_counter_gen;
   import js_pkg::*;

   localparam int W  = 4;
   localparam int PW = $clog2(2 * W);

   typedef struct {
      string          name;
      logic           en;
      logic           dir;
      logic           mode;
      logic           load;
      logic [W-1:0]   load_data;
      logic [W-1:0]   exp_data;
      logic [PW-1:0]  exp_phase;
      logic           exp_wrap;
      logic           exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[$];

   js_counter_gen_if #(.DATA_WID(W)) bus ();

   js_counter_gen #(.DATA_WID(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] ed, input logic [PW-1:0] ep,
                      input logic ew, input logic ee);
      total++;
      if (bus.Data !== ed || bus.phase !== ep || bus.wrap !== ew || bus.err !== ee) begin
         bad++;
         $display("FAIL %s: got Data=%b phase=%0d wrap=%b err=%b, want Data=%b phase=%0d wrap=%b err=%b",
                  name, bus.Data, bus.phase, bus.wrap, bus.err, ed, ep, ew, ee);
      end else begin
         $display("ok   %s: Data=%b phase=%0d wrap=%b err=%b", name, bus.Data, bus.phase, bus.wrap, bus.err);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.en        = v.en;
      bus.dir       = v.dir;
      bus.mode      = v.mode;
      bus.load      = v.load;
      bus.load_data = v.load_data;
      @(posedge clk);
      #1;
      chk(v.name, v.exp_data, v.exp_phase, v.exp_wrap, v.exp_err);
   endtask

   initial begin
      bus.en = 1'b0; bus.dir = JS_DIR_UP; bus.mode = JS_MODE_JOHNSON;
      bus.load = 1'b0; bus.load_data = '0;

      //             name         en dir mode ld  ld_data  data    ph wrap err
      vecs.push_back('{"js_up1",   1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0});
      vecs.push_back('{"js_up2",   1, 0, 0, 0, 4'b0000, 4'b0111, 3, 0, 0});
      vecs.push_back('{"js_up3",   1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0, 0});
      vecs.push_back('{"js_up4",   1, 0, 0, 0, 4'b0000, 4'b1110, 5, 0, 0});
      vecs.push_back('{"js_up5",   1, 0, 0, 0, 4'b0000, 4'b1100, 6, 0, 0});
      vecs.push_back('{"js_up6",   1, 0, 0, 0, 4'b0000, 4'b1000, 7, 0, 0});
      vecs.push_back('{"js_up7",   1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0});
      vecs.push_back('{"js_dn1",   1, 1, 0, 0, 4'b0000, 4'b1000, 7, 1, 0});
      vecs.push_back('{"js_dn2",   1, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0});
      vecs.push_back('{"hold",     0, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0});
      vecs.push_back('{"ld_wins",  1, 0, 0, 1, 4'b0001, 4'b0001, 1, 0, 0});
      vecs.push_back('{"rg_up1",   1, 0, 1, 0, 4'b0000, 4'b0010, 1, 0, 0});
      vecs.push_back('{"rg_up2",   1, 0, 1, 0, 4'b0000, 4'b0100, 2, 0, 0});
      vecs.push_back('{"rg_up3",   1, 0, 1, 0, 4'b0000, 4'b1000, 3, 0, 0});
      vecs.push_back('{"rg_up4",   1, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0});
      vecs.push_back('{"rg_dn1",   1, 1, 1, 0, 4'b0000, 4'b1000, 3, 1, 0});
      vecs.push_back('{"js_view",  0, 0, 0, 0, 4'b0000, 4'b1000, 7, 0, 0});
      vecs.push_back('{"ld_bad",   1, 0, 0, 1, 4'b0110, 4'b0110, 0, 0, 0});

      // Asynchronous reset entry and release
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset", 4'b0001, 1, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Illegal state after load: recovery or continued shifting
`ifdef JS_SELF_CORRECT_EN
      apply('{"bad_next",  1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 1});
      apply('{"bad_next2", 1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0});
      apply('{"ld_0011",   0, 0, 0, 1, 4'b0011, 4'b0011, 2, 0, 0});
      apply('{"to_ring",   0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 1});
      apply('{"to_js",     0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0});
`else
      apply('{"bad_next",  1, 0, 0, 0, 4'b0000, 4'b1101, 0, 0, 1});
      apply('{"bad_next2", 1, 0, 0, 0, 4'b0000, 4'b1010, 0, 0, 1});
      apply('{"ld_0011",   0, 0, 0, 1, 4'b0011, 4'b0011, 2, 0, 1});
      apply('{"to_ring",   0, 0, 1, 0, 4'b0000, 4'b0011, 0, 0, 1});
      apply('{"to_js",     0, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0});
`endif

      // Reset mid-count, between edges, right after a wrap
      apply('{"ld_1000",   0, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0});
      apply('{"pre_rst",   1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0});
      bus.mode = JS_MODE_RING;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 4'b0001, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", 4'b0001, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      apply('{"post_rst",  1, 0, 1, 0, 4'b0000, 4'b0010, 1, 0, 0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
